// File: rtl/led_seq_pkg.sv
// Shared types, key patterns and helpers for the LED mode sequencer.
// Mode/state enums, engine key patterns, ms-to-cycles conversion.
package led_seq_pkg;

  typedef enum logic [2:0] {
    MODE_NONE = 3'd0,
    MODE_SL   = 3'd1,
    MODE_RL   = 3'd2,
    MODE_WL   = 3'd3,
    MODE_PWM  = 3'd4
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ABORT,
    ST_GAP
  } state_e;

  // {key_2, key_3, key_4}, active-low
  localparam logic [2:0] PAT_SL   = 3'b011;
  localparam logic [2:0] PAT_RL   = 3'b101;
  localparam logic [2:0] PAT_WL   = 3'b110;
  localparam logic [2:0] PAT_PWM  = 3'b001;
  localparam logic [2:0] PAT_IDLE = 3'b111;

  function automatic logic [63:0] ms_to_cycles(
    input logic [63:0] freq,
    input logic [63:0] ms
  );
    return (freq * ms) / 64'd1000;
  endfunction

  function automatic logic [2:0] mode_pattern(input mode_e m);
    case (m)
      MODE_SL:  return PAT_SL;
      MODE_RL:  return PAT_RL;
      MODE_WL:  return PAT_WL;
      MODE_PWM: return PAT_PWM;
      default:  return PAT_IDLE;
    endcase
  endfunction

  function automatic mode_e auto_mode(input logic [1:0] idx);
    case (idx)
      2'd0:    return MODE_SL;
      2'd1:    return MODE_RL;
      2'd2:    return MODE_WL;
      default: return MODE_PWM;
    endcase
  endfunction

endpackage

// File: rtl/led_mode_sequencer_debounce.sv
// Single-key debouncer: accepts a level after DEB stable cycles.
// Ports: clk, rst_n, key (raw, active-low), stable level, press pulse.
module key_debounce #(
  parameter int unsigned DEB = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic stable,
  output logic press
);

  localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB - 1);

  logic [CW-1:0] cnt_q;

  // Any return of the raw input to the accepted level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b1;
      press  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      press <= 1'b0;
      if (key == stable) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        stable <= key;
        press  <= ~key;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_mode_sequencer.sv
// Front-end controller: debounced keys -> mode runs on the LED engine.
// Ports: clk, rst_n, i_key, i_auto, i_done; o_start, o_key_*, o_matrix_rst_n, o_busy, o_mode, o_timeout.
module led_mode_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned P_FREQUENCY    = 50_000_000,
  parameter int unsigned P_DEBOUNCE_MS  = 20,
  parameter int unsigned P_TIMEOUT_MS   = 2000,
  parameter int unsigned P_AUTO_GAP_MS  = 500,
  parameter int unsigned P_ABORT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_key,
  input  logic       i_auto,
  input  logic       i_done,
  output logic       o_start,
  output logic       o_key_2,
  output logic       o_key_3,
  output logic       o_key_4,
  output logic       o_matrix_rst_n,
  output logic       o_busy,
  output logic [2:0] o_mode,
  output logic       o_timeout
);

  localparam logic [63:0] DEB_L =
    ms_to_cycles(64'(P_FREQUENCY), 64'(P_DEBOUNCE_MS));
  localparam logic [63:0] TMO_L =
    ms_to_cycles(64'(P_FREQUENCY), 64'(P_TIMEOUT_MS));
  localparam logic [63:0] GAP_L =
    ms_to_cycles(64'(P_FREQUENCY), 64'(P_AUTO_GAP_MS));

  localparam int unsigned DEB = 32'(DEB_L);
  localparam int TW = (TMO_L > 64'd1) ? $clog2(TMO_L) : 1;
  localparam int GW = (GAP_L > 64'd1) ? $clog2(GAP_L) : 1;
  localparam int AW =
    (P_ABORT_CYCLES > 1) ? $clog2(P_ABORT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_L - 64'd1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_L - 64'd1);
  localparam logic [AW-1:0] ABT_LAST = AW'(P_ABORT_CYCLES - 1);

  logic [3:0] key_stable;
  logic [3:0] key_press;
  logic [3:0] key_hit;

  for (genvar g = 0; g < 4; g++) begin : g_deb
    key_debounce #(.DEB(DEB)) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .key    (i_key[g]),
      .stable (key_stable[g]),
      .press  (key_press[g])
    );
  end

  assign key_hit = key_press & ~key_stable;

  mode_e hit_mode;

  always_comb begin
    hit_mode = MODE_NONE;
    priority case (1'b1)
      key_hit[1]: hit_mode = MODE_SL;
      key_hit[2]: hit_mode = MODE_RL;
      key_hit[3]: hit_mode = MODE_WL;
      key_hit[0]: hit_mode = MODE_PWM;
      default:    hit_mode = MODE_NONE;
    endcase
  end

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  mode_e         pend_mode;
  logic          pend_valid, pend_clr;
  logic          armed, arm_set, arm_clr;
  logic [1:0]    auto_idx;
  logic [TW-1:0] tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic [AW-1:0] abt_cnt;
  logic          tmo_hit, timeout_q, mrst_q;
  logic          start, busy;
  logic [2:0]    pat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    pend_clr = 1'b0;
    arm_set  = 1'b0;
    arm_clr  = 1'b0;
    tmo_hit  = 1'b0;
    start    = 1'b0;
    busy     = 1'b0;
    pat      = PAT_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_valid) begin
          mode_d   = pend_mode;
          pend_clr = 1'b1;
          arm_clr  = 1'b1;
          state_d  = ST_ISSUE;
        end else if (i_auto && armed) begin
          mode_d  = auto_mode(auto_idx);
          arm_clr = 1'b1;
          state_d = ST_ISSUE;
        end else if (i_auto) begin
          state_d = ST_GAP;
        end else begin
          arm_clr = 1'b1;
        end
      end
      ST_ISSUE: begin
        start   = 1'b1;
        busy    = 1'b1;
        pat     = mode_pattern(mode_q);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (i_done) begin
          state_d = ST_IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = ST_ABORT;
        end else if (pend_valid && mode_q == MODE_PWM) begin
          // PWM never finishes, so a new request preempts it
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        busy = 1'b1;
        if (abt_cnt == ABT_LAST) state_d = ST_IDLE;
      end
      ST_GAP: begin
        if (!i_auto || pend_valid) begin
          state_d = ST_IDLE;
        end else if (gap_cnt == GAP_LAST) begin
          arm_set = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_NONE;
      pend_valid <= 1'b0;
      pend_mode  <= MODE_NONE;
      armed      <= 1'b0;
      auto_idx   <= '0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      abt_cnt    <= '0;
      timeout_q  <= 1'b0;
      mrst_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      timeout_q <= tmo_hit;
      mrst_q    <= 1'b1;
      // a fresh press overrides the clear from the same cycle
      if (|key_hit) begin
        pend_valid <= 1'b1;
        pend_mode  <= hit_mode;
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
      if (arm_set)      armed <= 1'b1;
      else if (arm_clr) armed <= 1'b0;
      if (state_q == ST_ISSUE) auto_idx <= auto_idx + 1'b1;
      tmo_cnt <= (state_q == ST_WAIT) ? tmo_cnt + 1'b1 : '0;
      gap_cnt <= (state_q == ST_GAP) ? gap_cnt + 1'b1 : '0;
      abt_cnt <= (state_q == ST_ABORT) ? abt_cnt + 1'b1 : '0;
    end
  end

  assign o_start                   = start;
  assign {o_key_2, o_key_3, o_key_4} = pat;
  assign o_busy                    = busy;
  assign o_mode                    = mode_q;
  assign o_timeout                 = timeout_q;
  assign o_matrix_rst_n            = mrst_q & (state_q != ST_ABORT);

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer at 1 cycle per ms.
// Covers reset, single runs, glitch, timeout, preemption, auto cycling.
module tb_led_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key;
  logic       auto_en;
  logic       done;
  logic       o_start, o_key_2, o_key_3, o_key_4;
  logic       o_matrix_rst_n, o_busy, o_timeout;
  logic [2:0] o_mode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_mode_sequencer #(
    .P_FREQUENCY   (1000),
    .P_DEBOUNCE_MS (20),
    .P_TIMEOUT_MS  (200),
    .P_AUTO_GAP_MS (50),
    .P_ABORT_CYCLES(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_key         (key),
    .i_auto        (auto_en),
    .i_done        (done),
    .o_start       (o_start),
    .o_key_2       (o_key_2),
    .o_key_3       (o_key_3),
    .o_key_4       (o_key_4),
    .o_matrix_rst_n(o_matrix_rst_n),
    .o_busy        (o_busy),
    .o_mode        (o_mode),
    .o_timeout     (o_timeout)
  );

  // {start, key2..4, busy, mode, timeout, matrix_rst_n}
  localparam logic [9:0] RST_VEC = 10'b0_111_0_000_0_0;

  function automatic logic [9:0] out_vec();
    return {o_start, o_key_2, o_key_3, o_key_4, o_busy,
            o_mode, o_timeout, o_matrix_rst_n};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; key = 4'hF; auto_en = 1'b0; done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++; $display("FAIL reset_outputs got=%b exp=%b", out_vec(), RST_VEC);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (o_matrix_rst_n !== 1'b0) begin
      bad++; $display("FAIL mrst_before_edge got=%b exp=0", o_matrix_rst_n);
    end
    @(posedge clk); #1;
    total++;
    if (o_matrix_rst_n !== 1'b1) begin
      bad++; $display("FAIL mrst_after_edge got=%b exp=1", o_matrix_rst_n);
    end
  endtask

  task automatic test_single();
    int n = 0, sk = -1, tn = 0;
    logic [2:0] sp = 3'b000;
    logic [2:0] sm = 3'b000;
    key = 4'b1011;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (o_start) begin
        n++;
        if (sk < 0) begin
          sk = k; sp = {o_key_2, o_key_3, o_key_4}; sm = o_mode;
        end
      end
      if (o_timeout) tn++;
      if (k == 22) begin
        total++;
        if ({o_key_2, o_key_3, o_key_4} !== 3'b111) begin
          bad++; $display("FAIL single_pat_idle got=%b exp=111",
                          {o_key_2, o_key_3, o_key_4});
        end
      end
      if (k == 24) key = 4'hF;
      if (k == 26) begin
        total++;
        if (o_busy !== 1'b1) begin
          bad++; $display("FAIL single_busy_run got=%b exp=1", o_busy);
        end
      end
      if (k == 27) begin
        total++;
        if (o_busy !== 1'b0) begin
          bad++; $display("FAIL single_busy_fall got=%b exp=0", o_busy);
        end
      end
      done = (k == 26);
    end
    total++;
    if (sk != 21) begin
      bad++; $display("FAIL single_start_cycle got=%0d exp=21", sk);
    end
    total++;
    if (n != 1) begin
      bad++; $display("FAIL single_start_count got=%0d exp=1", n);
    end
    total++;
    if (sp !== 3'b101) begin
      bad++; $display("FAIL single_pattern got=%b exp=101", sp);
    end
    total++;
    if (sm !== 3'd2) begin
      bad++; $display("FAIL single_mode got=%0d exp=2", sm);
    end
    total++;
    if (tn != 0) begin
      bad++; $display("FAIL single_timeout got=%0d exp=0", tn);
    end
  endtask

  task automatic test_glitch();
    int n = 0, bz = 0;
    key = 4'b1101;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (o_start) n++;
      if (o_busy) bz++;
      if (k == 9) key = 4'hF;
    end
    total++;
    if (n != 0) begin
      bad++; $display("FAIL glitch_start got=%0d exp=0", n);
    end
    total++;
    if (bz != 0) begin
      bad++; $display("FAIL glitch_busy got=%0d exp=0", bz);
    end
  endtask

  task automatic test_timeout();
    int sk = -1, tk = -1, tn = 0, rk = -1, rn = 0;
    logic [2:0] sp = 3'b000;
    key = 4'b1110;
    for (int k = 0; k < 240; k++) begin
      @(posedge clk); #1;
      if (o_start && sk < 0) begin
        sk = k; sp = {o_key_2, o_key_3, o_key_4};
      end
      if (o_timeout) begin
        tn++; if (tk < 0) tk = k;
      end
      if (!o_matrix_rst_n) begin
        rn++; if (rk < 0) rk = k;
      end
      if (k == 24) key = 4'hF;
    end
    total++;
    if (sk != 21 || sp !== 3'b001) begin
      bad++; $display("FAIL pwm_start got=%0d/%b exp=21/001", sk, sp);
    end
    total++;
    if (tk != 222 || tn != 1) begin
      bad++; $display("FAIL pwm_timeout got=%0d x%0d exp=222 x1", tk, tn);
    end
    total++;
    if (rk != 222 || rn != 2) begin
      bad++; $display("FAIL pwm_abort got=%0d x%0d exp=222 x2", rk, rn);
    end
    total++;
    if (o_mode !== 3'd4 || o_busy !== 1'b0) begin
      bad++; $display("FAIL pwm_end got=%0d/%b exp=4/0", o_mode, o_busy);
    end
  endtask

  task automatic test_preempt();
    int n = 0, sk = -1, tn = 0, rk = -1, rn = 0;
    logic [2:0] sp = 3'b000;
    logic [2:0] sm = 3'b000;
    key = 4'b1110;
    for (int k = 0; k < 115; k++) begin
      @(posedge clk); #1;
      if (o_start) begin
        n++;
        if (n == 2) begin
          sk = k; sp = {o_key_2, o_key_3, o_key_4}; sm = o_mode;
        end
      end
      if (o_timeout) tn++;
      if (!o_matrix_rst_n) begin
        rn++; if (rk < 0) rk = k;
      end
      if (k == 24) key = 4'hF;
      if (k == 72) key = 4'b0111;
      if (k == 97) key = 4'hF;
      done = (k == 100);
    end
    total++;
    if (rk != 94 || rn != 2) begin
      bad++; $display("FAIL preempt_abort got=%0d x%0d exp=94 x2", rk, rn);
    end
    total++;
    if (sk != 97 || sp !== 3'b110) begin
      bad++; $display("FAIL preempt_start got=%0d/%b exp=97/110", sk, sp);
    end
    total++;
    if (sm !== 3'd3) begin
      bad++; $display("FAIL preempt_mode got=%0d exp=3", sm);
    end
    total++;
    if (tn != 0) begin
      bad++; $display("FAIL preempt_timeout got=%0d exp=0", tn);
    end
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL preempt_end_busy got=%b exp=0", o_busy);
    end
  endtask

  task automatic test_auto();
    int sk[8];
    logic [2:0] sp[8];
    int n = 0, da = -1, tk = -1, tn = 0;
    int ek[5] = '{51, 114, 177, 240, 495};
    logic [2:0] ep[5] = '{3'b011, 3'b101, 3'b110, 3'b001, 3'b011};
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    auto_en = 1'b1;
    for (int k = 0; k < 520; k++) begin
      @(posedge clk); #1;
      if (o_start) begin
        if (n < 8) begin
          sk[n] = k; sp[n] = {o_key_2, o_key_3, o_key_4};
        end
        n++;
        if ({o_key_2, o_key_3, o_key_4} != 3'b001) da = k + 10;
      end
      if (o_timeout) begin
        tn++; if (tk < 0) tk = k;
      end
      if (k == 500) auto_en = 1'b0;
      done = (k == da);
    end
    total++;
    if (n != 5) begin
      bad++; $display("FAIL auto_count got=%0d exp=5", n);
    end
    for (int i = 0; i < 5; i++) begin
      if (i < n) begin
        total++;
        if (sk[i] != ek[i] || sp[i] !== ep[i]) begin
          bad++;
          $display("FAIL auto_run%0d got=%0d/%b exp=%0d/%b",
                   i, sk[i], sp[i], ek[i], ep[i]);
        end
      end
    end
    total++;
    if (tk != 441 || tn != 1) begin
      bad++; $display("FAIL auto_timeout got=%0d x%0d exp=441 x1", tk, tn);
    end
    total++;
    if (o_busy !== 1'b0) begin
      bad++; $display("FAIL auto_end_busy got=%b exp=0", o_busy);
    end
  endtask

  task automatic test_reset_midrun();
    int n = 0;
    key = 4'b1011;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (k == 24) key = 4'hF;
    end
    total++;
    if (o_busy !== 1'b1 || o_mode !== 3'd2) begin
      bad++; $display("FAIL midrun_pre got=%b/%0d exp=1/2", o_busy, o_mode);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_vec() !== RST_VEC) begin
      bad++; $display("FAIL midrun_async got=%b exp=%b", out_vec(), RST_VEC);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    total++;
    if (o_matrix_rst_n !== 1'b0) begin
      bad++; $display("FAIL midrun_mrst_hold got=%b exp=0", o_matrix_rst_n);
    end
    @(posedge clk); #1;
    total++;
    if (o_matrix_rst_n !== 1'b1) begin
      bad++; $display("FAIL midrun_mrst_rise got=%b exp=1", o_matrix_rst_n);
    end
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      if (o_start) n++;
    end
    total++;
    if (n != 0) begin
      bad++; $display("FAIL midrun_spurious got=%0d exp=0", n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_timeout();
    test_preempt();
    test_auto();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
